// File: rtl/dual_port_delay_mem.sv
// Dual-port 32-bit word memory with per-request programmable latency and a port-2 IO window.
// Optional build macro MEM_MISALIGN_ERR_EN turns misaligned port-2 accesses into error completions.
module dual_port_delay_mem #(
    parameter int          DELAY_BITS = 4,
    parameter int          ADDR_WIDTH = 14,
    parameter logic [31:0] IO_BASE    = 32'h1100_0000
) (
    input  logic                  MEM_CLK,
    input  logic                  RST,
    input  logic [DELAY_BITS-1:0] DELAY,
    input  logic                  MEM_RDEN1,
    input  logic [ADDR_WIDTH-1:0] MEM_ADDR1,
    input  logic                  MEM_RDEN2,
    input  logic                  MEM_WE2,
    input  logic [31:0]           MEM_ADDR2,
    input  logic [31:0]           MEM_DIN2,
    input  logic [1:0]            MEM_SIZE,
    input  logic                  MEM_SIGN,
    input  logic [31:0]           IO_IN,
    output logic                  IO_WR,
    output logic [31:0]           IO_ADDR,
    output logic [31:0]           IO_DOUT,
    output logic [31:0]           MEM_DOUT1,
    output logic [31:0]           MEM_DOUT2,
    output logic                  memValid1,
    output logic                  memValid2,
    output logic                  ERR2
);

    localparam logic IDLE = 1'b0;
    localparam logic BUSY = 1'b1;
    localparam int   DEPTH = 1 << ADDR_WIDTH;
    localparam logic [DELAY_BITS-1:0] CNT_ZERO = {DELAY_BITS{1'b0}};
    localparam logic [DELAY_BITS-1:0] CNT_ONE  = {{(DELAY_BITS-1){1'b0}}, 1'b1};

    // Lane extraction for loads; zext=1 zero-extends, zext=0 sign-extends.
    function automatic logic [31:0] load_lane(input logic [31:0] word, input logic [1:0] off,
                                              input logic [1:0] size, input logic zext);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (size)
            2'd0:    r = zext ? {24'h00_0000, b} : {{24{b[7]}}, b};
            2'd1:    r = zext ? {16'h0000, h} : {{16{h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] store_lane(input logic [31:0] word, input logic [1:0] off,
                                               input logic [1:0] size, input logic [31:0] data);
        logic [31:0] r;
        r = word;
        case (size)
            2'd0: r[{off, 3'b000} +: 8] = data[7:0];
            2'd1: begin
                if (off[1]) begin
                    r[31:16] = data[15:0];
                end else begin
                    r[15:0] = data[15:0];
                end
            end
            default: r = data;
        endcase
        return r;
    endfunction

    logic [31:0] mem_r [0:DEPTH-1];

    logic                  st1_r, valid1_r;
    logic [DELAY_BITS-1:0] cnt1_r;
    logic [ADDR_WIDTH-1:0] addr1_r;
    logic [31:0]           dout1_r;

    logic                  st2_r, valid2_r, err2_r, io_wr_r, we2_r, sign2_r;
    logic [DELAY_BITS-1:0] cnt2_r;
    logic [31:0]           addr2_r, din2_r, dout2_r, io_addr_r, io_dout_r;
    logic [1:0]            size2_r;

    logic                  done1_s, acc1_s, done2_s, acc2_s;
    logic                  is_io_s, misalign_s, mem_wr_s;
    logic [ADDR_WIDTH-1:0] idx2_s;
    logic [31:0]           old_word_s, rd_data_s, wr_word_s;

    // A port completes when its counter has run out; a new request may be taken on that same edge.
    always_comb begin
        done1_s    = (st1_r == BUSY) && (cnt1_r == CNT_ZERO);
        acc1_s     = MEM_RDEN1 && ((st1_r == IDLE) || done1_s);
        done2_s    = (st2_r == BUSY) && (cnt2_r == CNT_ZERO);
        acc2_s     = (MEM_WE2 || MEM_RDEN2) && ((st2_r == IDLE) || done2_s);
        idx2_s     = addr2_r[ADDR_WIDTH+1:2];
        is_io_s    = (addr2_r >= IO_BASE);
        old_word_s = mem_r[idx2_s];
        rd_data_s  = load_lane(old_word_s, addr2_r[1:0], size2_r, sign2_r);
        wr_word_s  = store_lane(old_word_s, addr2_r[1:0], size2_r, din2_r);
        mem_wr_s   = done2_s && we2_r && !is_io_s && !misalign_s && !RST;
    end

`ifdef MEM_MISALIGN_ERR_EN
    assign misalign_s = ((size2_r == 2'd1) && addr2_r[0]) ||
                        ((size2_r[1] == 1'b1) && (addr2_r[1:0] != 2'b00));
`else
    assign misalign_s = 1'b0;
`endif

    // Port-1 read FSM and output registers.
    always_ff @(posedge MEM_CLK) begin
        if (RST) begin
            st1_r    <= IDLE;
            cnt1_r   <= CNT_ZERO;
            addr1_r  <= {ADDR_WIDTH{1'b0}};
            valid1_r <= 1'b0;
            dout1_r  <= 32'h0000_0000;
        end else begin
            valid1_r <= done1_s;
            if (done1_s) begin
                dout1_r <= mem_r[addr1_r];
            end
            if (acc1_s) begin
                st1_r   <= BUSY;
                cnt1_r  <= DELAY;
                addr1_r <= MEM_ADDR1;
            end else if (done1_s) begin
                st1_r <= IDLE;
            end else if (st1_r == BUSY) begin
                cnt1_r <= cnt1_r - CNT_ONE;
            end
        end
    end

    // Port-2 read/write FSM, IO bypass and output registers.
    always_ff @(posedge MEM_CLK) begin
        if (RST) begin
            st2_r     <= IDLE;
            cnt2_r    <= CNT_ZERO;
            addr2_r   <= 32'h0000_0000;
            din2_r    <= 32'h0000_0000;
            size2_r   <= 2'd0;
            sign2_r   <= 1'b0;
            we2_r     <= 1'b0;
            valid2_r  <= 1'b0;
            err2_r    <= 1'b0;
            io_wr_r   <= 1'b0;
            io_addr_r <= 32'h0000_0000;
            io_dout_r <= 32'h0000_0000;
            dout2_r   <= 32'h0000_0000;
        end else begin
            valid2_r <= done2_s;
            err2_r   <= done2_s && misalign_s;
            io_wr_r  <= done2_s && we2_r && is_io_s && !misalign_s;
            if (done2_s && !misalign_s) begin
                if (is_io_s) begin
                    io_addr_r <= addr2_r;
                    if (we2_r) begin
                        io_dout_r <= din2_r;
                    end else begin
                        dout2_r <= IO_IN;
                    end
                end else if (!we2_r) begin
                    dout2_r <= rd_data_s;
                end
            end
            if (acc2_s) begin
                st2_r   <= BUSY;
                cnt2_r  <= DELAY;
                addr2_r <= MEM_ADDR2;
                din2_r  <= MEM_DIN2;
                size2_r <= MEM_SIZE;
                sign2_r <= MEM_SIGN;
                we2_r   <= MEM_WE2;
            end else if (done2_s) begin
                st2_r <= IDLE;
            end else if (st2_r == BUSY) begin
                cnt2_r <= cnt2_r - CNT_ONE;
            end
        end
    end

    // Array write port; contents survive reset, and a same-edge port-1 read sees the old word.
    always_ff @(posedge MEM_CLK) begin
        if (mem_wr_s) begin
            mem_r[idx2_s] <= wr_word_s;
        end
    end

    assign MEM_DOUT1 = dout1_r;
    assign MEM_DOUT2 = dout2_r;
    assign memValid1 = valid1_r;
    assign memValid2 = valid2_r;
    assign ERR2      = err2_r;
    assign IO_WR     = io_wr_r;
    assign IO_ADDR   = io_addr_r;
    assign IO_DOUT   = io_dout_r;

endmodule

// File: tb/tb_dual_port_delay_mem.sv
// Self-checking bench for dual_port_delay_mem: directed scenarios plus randomized traffic
// compared against a word-array reference model.
module tb_dual_port_delay_mem;

    localparam logic [31:0] IO_BASE = 32'h1100_0000;

    logic        MEM_CLK = 1'b0;
    logic        RST = 1'b1;
    logic [3:0]  DELAY = 4'd0;
    logic        MEM_RDEN1 = 1'b0;
    logic [13:0] MEM_ADDR1 = 14'd0;
    logic        MEM_RDEN2 = 1'b0;
    logic        MEM_WE2 = 1'b0;
    logic [31:0] MEM_ADDR2 = 32'd0;
    logic [31:0] MEM_DIN2 = 32'd0;
    logic [1:0]  MEM_SIZE = 2'd0;
    logic        MEM_SIGN = 1'b0;
    logic [31:0] IO_IN = 32'h8000_0001;
    logic        IO_WR, memValid1, memValid2, ERR2;
    logic [31:0] IO_ADDR, IO_DOUT, MEM_DOUT1, MEM_DOUT2;

    dual_port_delay_mem dut (
        .MEM_CLK(MEM_CLK), .RST(RST), .DELAY(DELAY),
        .MEM_RDEN1(MEM_RDEN1), .MEM_ADDR1(MEM_ADDR1),
        .MEM_RDEN2(MEM_RDEN2), .MEM_WE2(MEM_WE2), .MEM_ADDR2(MEM_ADDR2),
        .MEM_DIN2(MEM_DIN2), .MEM_SIZE(MEM_SIZE), .MEM_SIGN(MEM_SIGN),
        .IO_IN(IO_IN), .IO_WR(IO_WR), .IO_ADDR(IO_ADDR), .IO_DOUT(IO_DOUT),
        .MEM_DOUT1(MEM_DOUT1), .MEM_DOUT2(MEM_DOUT2),
        .memValid1(memValid1), .memValid2(memValid2), .ERR2(ERR2)
    );

    always #5 MEM_CLK = ~MEM_CLK;

    int total = 0;
    int pass_cnt = 0;
    logic [31:0] mdl [0:16383];
    logic [31:0] last_dout2 = 32'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) & 32'h0000_3FFF);
    endfunction

    // Reference load: pick the lane by byte offset, then extend (sign=1 means zero-extend).
    function automatic logic [31:0] ref_read(input logic [31:0] w, input logic [1:0] off,
                                             input logic [1:0] size, input logic sign);
        logic [31:0] v;
        case (size)
            2'd0: begin
                v = (w >> (8 * off)) & 32'h0000_00FF;
                if (!sign && v >= 32'h80) v = v | 32'hFFFF_FF00;
            end
            2'd1: begin
                v = (w >> (off[1] ? 16 : 0)) & 32'h0000_FFFF;
                if (!sign && v >= 32'h8000) v = v | 32'hFFFF_0000;
            end
            default: v = w;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] ref_write(input logic [31:0] w, input logic [1:0] off,
                                              input logic [1:0] size, input logic [31:0] d);
        logic [31:0] m;
        int sh;
        case (size)
            2'd0: begin sh = 8 * off; m = 32'h0000_00FF; end
            2'd1: begin sh = off[1] ? 16 : 0; m = 32'h0000_FFFF; end
            default: begin sh = 0; m = 32'hFFFF_FFFF; end
        endcase
        return (w & ~(m << sh)) | ((d & m) << sh);
    endfunction

    // Issue one port-2 request and return the number of edges until memValid2 (-1 on timeout).
    task automatic p2_op(input logic we, input logic [31:0] addr, input logic [31:0] din,
                         input logic [1:0] size, input logic sign, input logic [3:0] dly,
                         output int lat);
        @(negedge MEM_CLK);
        MEM_WE2 = we; MEM_RDEN2 = !we; MEM_ADDR2 = addr; MEM_DIN2 = din;
        MEM_SIZE = size; MEM_SIGN = sign; DELAY = dly;
        @(posedge MEM_CLK);
        #1 MEM_WE2 = 1'b0; MEM_RDEN2 = 1'b0;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge MEM_CLK);
            @(negedge MEM_CLK);
            if (memValid2) begin lat = k; break; end
        end
    endtask

    task automatic p1_rd(input logic [13:0] addr, input logic [3:0] dly, output int lat);
        @(negedge MEM_CLK);
        MEM_RDEN1 = 1'b1; MEM_ADDR1 = addr; DELAY = dly;
        @(posedge MEM_CLK);
        #1 MEM_RDEN1 = 1'b0;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge MEM_CLK);
            @(negedge MEM_CLK);
            if (memValid1) begin lat = k; break; end
        end
    endtask

    initial begin
        int lat;
        logic seen;
        logic [31:0] old4;

        // Reset state
        repeat (3) @(posedge MEM_CLK);
        @(negedge MEM_CLK);
        chk("rst_valids", {28'd0, memValid1, memValid2, IO_WR, ERR2}, 32'd0);
        chk("rst_dout1", MEM_DOUT1, 32'd0);
        chk("rst_dout2", MEM_DOUT2, 32'd0);
        chk("rst_io_addr", IO_ADDR, 32'd0);
        chk("rst_io_dout", IO_DOUT, 32'd0);
        RST = 1'b0;

        // Fill words 0..15 with known data
        for (int w = 0; w < 16; w++) begin
            mdl[w] = $urandom;
            p2_op(1'b1, 32'(w * 4), mdl[w], 2'd2, 1'b0, 4'd0, lat);
        end
        chk("fill_lat", 32'(lat), 32'd1);

        // Word write then port-1 read, DELAY=3
        p2_op(1'b1, 32'h10, 32'hDEAD_BEEF, 2'd2, 1'b0, 4'd3, lat);
        mdl[4] = 32'hDEAD_BEEF;
        chk("wr_lat_d3", 32'(lat), 32'd4);
        chk("wr_dout2_hold", MEM_DOUT2, last_dout2);
        @(posedge MEM_CLK); @(negedge MEM_CLK);
        chk("valid2_pulse_one_cycle", {31'd0, memValid2}, 32'd0);
        p1_rd(14'd4, 4'd3, lat);
        chk("rd1_lat_d3", 32'(lat), 32'd4);
        chk("rd1_data", MEM_DOUT1, 32'hDEAD_BEEF);

        // Byte / half loads with both extension modes
        p2_op(1'b0, 32'h13, 32'd0, 2'd0, 1'b0, 4'd1, lat);
        chk("byte_sext", MEM_DOUT2, 32'hFFFF_FFDE);
        p2_op(1'b0, 32'h13, 32'd0, 2'd0, 1'b1, 4'd1, lat);
        chk("byte_zext", MEM_DOUT2, 32'h0000_00DE);
        p2_op(1'b0, 32'h12, 32'd0, 2'd1, 1'b0, 4'd2, lat);
        chk("half_hi_sext", MEM_DOUT2, 32'hFFFF_DEAD);
        chk("half_lat_d2", 32'(lat), 32'd3);
        p2_op(1'b0, 32'h10, 32'd0, 2'd1, 1'b1, 4'd0, lat);
        chk("half_lo_zext", MEM_DOUT2, 32'h0000_BEEF);
        last_dout2 = MEM_DOUT2;

        // Byte store touches only its lane; wrapped alias of the same word
        p2_op(1'b1, 32'h11, 32'hFFFF_FF77, 2'd0, 1'b0, 4'd0, lat);
        mdl[4] = 32'hDEAD_77EF;
        chk("byte_wr_hold_dout2", MEM_DOUT2, last_dout2);
        p2_op(1'b0, 32'h0001_0010, 32'd0, 2'd3, 1'b0, 4'd0, lat);
        chk("byte_wr_wrap_read", MEM_DOUT2, 32'hDEAD_77EF);
        last_dout2 = MEM_DOUT2;

        // IO write, DELAY=0
        p2_op(1'b1, 32'h1100_0004, 32'h0000_005A, 2'd2, 1'b0, 4'd0, lat);
        chk("io_wr_lat", 32'(lat), 32'd1);
        chk("io_wr_strobe", {31'd0, IO_WR}, 32'd1);
        chk("io_wr_addr", IO_ADDR, 32'h1100_0004);
        chk("io_wr_data", IO_DOUT, 32'h0000_005A);
        chk("io_wr_dout2_hold", MEM_DOUT2, last_dout2);
        @(posedge MEM_CLK); @(negedge MEM_CLK);
        chk("io_wr_strobe_drop", {31'd0, IO_WR}, 32'd0);
        p1_rd(14'd1, 4'd0, lat);
        chk("io_wr_array_untouched", MEM_DOUT1, mdl[1]);

        // IO read returns IO_IN without extension
        p2_op(1'b0, IO_BASE + 32'd8, 32'd0, 2'd0, 1'b0, 4'd2, lat);
        chk("io_rd_data", MEM_DOUT2, 32'h8000_0001);
        chk("io_rd_no_strobe", {31'd0, IO_WR}, 32'd0);

        // Reset during a pending write aborts it
        @(negedge MEM_CLK);
        MEM_WE2 = 1'b1; MEM_ADDR2 = 32'h20; MEM_DIN2 = 32'h2222_2222;
        MEM_SIZE = 2'd2; DELAY = 4'd5;
        @(posedge MEM_CLK);
        #1 MEM_WE2 = 1'b0;
        seen = 1'b0;
        repeat (2) begin @(posedge MEM_CLK); @(negedge MEM_CLK); seen = seen | memValid2; end
        RST = 1'b1;
        @(posedge MEM_CLK);
        #1 RST = 1'b0;
        repeat (10) begin @(negedge MEM_CLK); seen = seen | memValid2; end
        chk("abort_no_valid", {31'd0, seen}, 32'd0);
        last_dout2 = 32'd0;
        p2_op(1'b0, 32'h20, 32'd0, 2'd2, 1'b0, 4'd1, lat);
        chk("abort_old_data", MEM_DOUT2, mdl[8]);
        last_dout2 = MEM_DOUT2;

        // Back-to-back port-1 reads with DELAY=1
        @(negedge MEM_CLK);
        MEM_RDEN1 = 1'b1; MEM_ADDR1 = 14'd4; DELAY = 4'd1;
        for (int k = 0; k < 10; k++) begin
            @(posedge MEM_CLK); @(negedge MEM_CLK);
            chk($sformatf("b2b_valid_k%0d", k), {31'd0, memValid1},
                (k >= 2 && (k % 2) == 0) ? 32'd1 : 32'd0);
        end
        chk("b2b_data", MEM_DOUT1, mdl[4]);
        MEM_RDEN1 = 1'b0;
        repeat (4) @(negedge MEM_CLK);

        // Same-word write and read completing together: read sees pre-write data
        old4 = mdl[4];
        @(negedge MEM_CLK);
        MEM_RDEN1 = 1'b1; MEM_ADDR1 = 14'd4;
        MEM_WE2 = 1'b1; MEM_ADDR2 = 32'h10; MEM_DIN2 = 32'hCAFE_F00D; MEM_SIZE = 2'd2;
        DELAY = 4'd2;
        @(posedge MEM_CLK);
        #1 MEM_RDEN1 = 1'b0; MEM_WE2 = 1'b0;
        repeat (3) @(posedge MEM_CLK);
        @(negedge MEM_CLK);
        chk("coll_valids", {30'd0, memValid1, memValid2}, 32'd3);
        chk("coll_pre_write", MEM_DOUT1, old4);
        mdl[4] = 32'hCAFE_F00D;
        p1_rd(14'd4, 4'd0, lat);
        chk("coll_post_write", MEM_DOUT1, 32'hCAFE_F00D);

        // Misaligned word write to 0x22
        p2_op(1'b1, 32'h22, 32'h1234_5678, 2'd2, 1'b0, 4'd1, lat);
`ifdef MEM_MISALIGN_ERR_EN
        chk("misal_err", {31'd0, ERR2}, 32'd1);
        chk("misal_lat", 32'(lat), 32'd2);
`else
        chk("misal_err_tied0", {31'd0, ERR2}, 32'd0);
        mdl[8] = 32'h1234_5678;
`endif
        p1_rd(14'd8, 4'd0, lat);
        chk("misal_word8", MEM_DOUT1, mdl[8]);
        // Misaligned half read at 0x13
        p2_op(1'b0, 32'h13, 32'd0, 2'd1, 1'b1, 4'd0, lat);
`ifdef MEM_MISALIGN_ERR_EN
        chk("misal_half_hold", MEM_DOUT2, last_dout2);
`else
        chk("misal_half_lane", MEM_DOUT2, ref_read(mdl[4], 2'd2, 2'd1, 1'b1));
        last_dout2 = MEM_DOUT2;
`endif

        // Randomized aligned traffic on words 0..15 with wrapped aliases
        for (int i = 0; i < 40; i++) begin
            int w;
            logic [1:0] sz, off;
            logic sg, we;
            logic [3:0] dly;
            logic [31:0] d, a;
            w = int'($urandom_range(0, 15));
            dly = 4'($urandom_range(0, 6));
            if ($urandom_range(0, 2) == 0) begin
                p1_rd(14'(w), dly, lat);
                chk($sformatf("rnd%0d_p1_lat", i), 32'(lat), 32'(dly) + 32'd1);
                chk($sformatf("rnd%0d_p1_data", i), MEM_DOUT1, mdl[w]);
            end else begin
                sz = 2'($urandom_range(0, 3));
                off = (sz == 2'd0) ? 2'($urandom_range(0, 3)) :
                      (sz == 2'd1) ? 2'(2 * $urandom_range(0, 1)) : 2'd0;
                sg = 1'($urandom_range(0, 1));
                we = 1'($urandom_range(0, 1));
                d = $urandom;
                a = 32'(w * 4) + 32'(off) + (32'($urandom_range(0, 31)) << 16);
                p2_op(we, a, d, sz, sg, dly, lat);
                chk($sformatf("rnd%0d_p2_lat", i), 32'(lat), 32'(dly) + 32'd1);
                if (we) begin
                    mdl[w] = ref_write(mdl[w], off, sz, d);
                    chk($sformatf("rnd%0d_wr_hold", i), MEM_DOUT2, last_dout2);
                end else begin
                    chk($sformatf("rnd%0d_rd_data", i), MEM_DOUT2, ref_read(mdl[w], off, sz, sg));
                    last_dout2 = MEM_DOUT2;
                end
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/dual_port_delay_mem.md
DUAL_PORT_DELAY_MEM -- requirements
Module: dual_port_delay_mem

Interface
REQ-001 SHALL have parameter DELAY_BITS, default 4: width of the per-request latency value.
REQ-002 SHALL have parameter ADDR_WIDTH, default 14: word-address width; depth is 2^ADDR_WIDTH 32-bit words.
REQ-003 SHALL have parameter IO_BASE, default 32'h1100_0000: byte addresses on port 2 that are >= IO_BASE are IO.
REQ-004 SHALL have the following ports, one clock, reset synchronous active-high:
  MEM_CLK  in  1  clock, all logic on rising edge
  RST  in  1  synchronous active-high reset
  DELAY  in  DELAY_BITS  extra wait cycles, sampled when a request is accepted
  MEM_RDEN1  in  1  port-1 read request
  MEM_ADDR1  in  ADDR_WIDTH  port-1 word address
  MEM_RDEN2  in  1  port-2 read request
  MEM_WE2  in  1  port-2 write request; has priority over MEM_RDEN2
  MEM_ADDR2  in  32  port-2 byte address
  MEM_DIN2  in  32  port-2 write data, right-aligned
  MEM_SIZE  in  2  0 byte, 1 half, 2 word; 3 is treated as word
  MEM_SIGN  in  1  1 zero-extend, 0 sign-extend
  IO_IN  in  32  IO read data
  IO_WR  out  1  one-cycle IO write strobe
  IO_ADDR  out  32  registered IO byte address
  IO_DOUT  out  32  registered IO write data
  MEM_DOUT1  out  32  port-1 read data
  MEM_DOUT2  out  32  port-2 read data
  memValid1  out  1  port-1 completion pulse
  memValid2  out  1  port-2 completion pulse
  ERR2  out  1  port-2 misalignment error pulse

Function
REQ-005 Each port SHALL run an independent FSM with states IDLE and BUSY, plus a DELAY_BITS-wide down-counter.
REQ-006 In IDLE, an asserted request SHALL be accepted: latch the address, data, size, sign and DELAY, then enter BUSY.
REQ-007 BUSY SHALL decrement the counter. When the counter equals 0, the port SHALL complete, pulse memValid for exactly one cycle and return to IDLE.
REQ-008 Latency from the acceptance edge to memValid high SHALL be DELAY+1 cycles, so DELAY=0 gives valid on the next cycle.
REQ-009 Request inputs SHALL be ignored while BUSY. A request present in the cycle memValid is high SHALL be accepted on that edge, giving back-to-back operation.
REQ-010 Port-2 reads SHALL extract the lane selected by MEM_ADDR2[1:0] at byte or half size, and extend it per MEM_SIGN; word reads SHALL return the full word.
REQ-011 Port-2 writes SHALL update only the addressed byte, half or word lanes, and only on the completion cycle.
REQ-012 MEM_DOUT1 and MEM_DOUT2 SHALL hold their last completed value until the next completion on that port.
REQ-013 Port-2 addresses >= IO_BASE SHALL bypass the array.
  Read: MEM_DOUT2 = IO_IN sampled on the completion cycle, with no extension.
  Write: IO_WR pulses with memValid2, with IO_ADDR and IO_DOUT valid in that cycle.
REQ-014 For array accesses, address bits above ADDR_WIDTH+1 SHALL be ignored, so addresses wrap modulo the depth.
REQ-015 If a port-2 write and a port-1 read complete on the same word in the same cycle, port 1 SHALL return the pre-write data.

Reset
REQ-016 While RST is high, both FSMs SHALL go to IDLE, counters to 0, and memValid1, memValid2, IO_WR, ERR2 to 0. MEM_DOUT1, MEM_DOUT2, IO_ADDR and IO_DOUT SHALL go to 0.
REQ-017 Reset during BUSY SHALL abort the request with no write and no valid pulse. Array contents SHALL NOT be cleared.

Configuration
REQ-018 With MEM_MISALIGN_ERR_EN defined, a port-2 access SHALL be misaligned if it is a half with MEM_ADDR2[0]=1, or a word with MEM_ADDR2[1:0]!=0.
  A misaligned access SHALL complete with normal latency and pulse ERR2 with memValid2.
  It SHALL perform no array or IO write, and MEM_DOUT2 SHALL be unchanged.
REQ-019 Without MEM_MISALIGN_ERR_EN, ERR2 SHALL be tied 0.
  A misaligned half SHALL use lane (ADDR2[1]). A misaligned word SHALL ignore ADDR2[1:0].

Verification
REQ-020 Stimulus: DELAY=3, write word 0xDEADBEEF at byte address 0x10 via port 2, then read port 1 at word address 4.
  Response: memValid2 at cycle 4 after acceptance, then MEM_DOUT1=0xDEADBEEF with memValid1 at cycle 4.
REQ-021 Stimulus: byte read at address 0x13 of 0xDEADBEEF with MEM_SIGN=0, then with MEM_SIGN=1.
  Response: MEM_DOUT2=0xFFFFFFDE, then MEM_DOUT2=0x000000DE.
REQ-022 Stimulus: DELAY=0, write to 0x1100_0004 with data 0x5A.
  Response: next cycle IO_WR=1, IO_ADDR=0x1100_0004, IO_DOUT=0x5A, memValid2=1, array unchanged.
REQ-023 Stimulus: DELAY=5, RST asserted two cycles after a port-2 write is accepted.
  Response: no memValid2 pulse, and a later read of that address returns the old data.
REQ-024 Stimulus: MEM_RDEN1 held high continuously with DELAY=1.
  Response: memValid1 pulses every 2 cycles with no idle gap.
REQ-025 Stimulus: with MEM_MISALIGN_ERR_EN, word write to 0x22.
  Response: ERR2=1 with memValid2, and word 8 is unchanged.
